cost_tracker: RTL
=================

# cost_tracker

- Sink for the permutation stream of the job-assignment search; the source emits eight (work, job) pairs per permutation.
- Looks up each pair's cost in the external cost ROM and sums the eight costs per permutation.
- Tracks the minimum total cost and how many permutations reach it.
- After the final permutation, presents MinCost/MatchCount and asserts Valid.

## Interface
Parameters:
- N, 8: workers/jobs per permutation; index width INDEX_BIT = 3.
- COST_BIT, 7: width of one cost entry.
- SUM_BIT, 10: sum width; holds N*(2^COST_BIT-1) = 1016.
- CNT_BIT, 16: match counter width; holds 8! = 40320.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  pair qualifier; gaps allowed at any point.
- in_work  in  3  worker index; 0 opens a permutation, N-1 closes it.
- in_job  in  3  job assigned to in_work.
- in_last  in  1  with in_valid and in_work==N-1: final pair of the final permutation.
- W  out  3  cost ROM worker address, registered.
- J  out  3  cost ROM job address, registered.
- Cost  in  COST_BIT  ROM data, valid the cycle after W/J.
- MinCost  out  SUM_BIT  minimum permutation sum.
- MatchCount  out  CNT_BIT  number of permutations whose sum equals MinCost.
- Valid  out  1  result final; level signal.

## Operation
- Stage 1 (addr): on in_valid and not done: W<=in_work, J<=in_job. Tag regs v1/open1/close1/last1 register in_valid, in_work==0, in_work==N-1, in_last. W/J hold when idle.
- Stage 2 (acc): when v2 (v1 delayed) is set:
  - open2: acc <= Cost (zero-extended), discarding any prior partial sum.
  - otherwise: acc <= acc + Cost.
  - close2: also set sum_v for one cycle and carry last.
- Stage 3 (cmp), on sum_v:
  - acc < MinCost: MinCost <= acc, MatchCount <= 1.
  - acc == MinCost: MatchCount <= MatchCount + 1, saturating at 2^CNT_BIT-1.
  - acc > MinCost: no change.
  - carried last set: done <= 1.
- Valid <= done, one cycle later. Once Valid is high, all inputs are ignored, the pipeline freezes, and outputs hold until RST.
- State: IDLE/RUN (not done) -> DONE (Valid) -> IDLE on RST only.
- Reset values: W=0, J=0, acc=0, all tag regs 0, MinCost=2^SUM_BIT-1 (1023), MatchCount=0, Valid=0. Because 1023 exceeds the maximum sum, the first permutation always becomes the minimum.
- Out-of-order in_work is not checked; only indices 0 and N-1 affect control. in_last without in_work==N-1 is ignored.

## Timing
- in_valid pair at cycle t:
  - W/J visible at t+1.
  - Cost sampled at end of t+2.
  - acc final (for a close pair) visible at t+3.
  - MinCost/MatchCount updated visible at t+4.
  - Valid high at t+5 if last.
- Throughput: one pair per cycle; a permutation open may directly follow a close with no bubble. When open2 and the preceding close (now in stage 3) are back to back, stage 3 compares the registered sum before acc is overwritten.
- Reset mid-stream: all in-flight pairs are dropped. Outputs return to reset values in the cycle after RST.
- Reset and in_valid in the same cycle: RST wins and the pair is lost.

## Structure
- Package cost_tracker_pkg: N, INDEX_BIT, COST_BIT, SUM_BIT, CNT_BIT, MINCOST_INIT = {SUM_BIT{1'b1}}.
- The same package supplies the constants the permutation source uses.
- Sub-module min_count_tracker: stage 3. Inputs sum, sum_v, last, RST. Outputs MinCost, MatchCount, done. Reused by the bench's reference model.

## Test plan
- Cost ROM all 5; 8! permutations in natural order, in_last on the final one -> MinCost=40, MatchCount=40320, Valid high 5 cycles after the last pair.
- Cost[w][j] = (w==j)?1:100; identity permutation first -> MinCost=8, MatchCount=1.
- Three permutations with sums 300, 250, 250 (last on the third) -> MinCost=250, MatchCount=2.
- Same as the previous scenario with a random 0-3 cycle bubble inserted between every pair -> identical result and Valid timing relative to the final pair (t+5).
- RST asserted for one cycle mid-permutation, then one clean permutation with sum 64 and in_last -> MinCost=64, MatchCount=1; pre-reset pairs have no effect.
- After Valid, drive more pairs with cost 0 -> MinCost, MatchCount and Valid unchanged.

Source files
------------

// File: rtl/cost_tracker_pkg.sv
// Shared constants for the job-assignment search: permutation size, cost/sum/count
// widths and the minimum-tracker start value.
package cost_tracker_pkg;

  localparam int N         = 8;
  localparam int INDEX_BIT = 3;
  localparam int COST_BIT  = 7;
  localparam int SUM_BIT   = 10;
  localparam int CNT_BIT   = 16;

  localparam logic [SUM_BIT-1:0]   MINCOST_INIT = {SUM_BIT{1'b1}};
  localparam logic [CNT_BIT-1:0]   CNT_MAX      = {CNT_BIT{1'b1}};
  localparam logic [INDEX_BIT-1:0] IDX_FIRST    = {INDEX_BIT{1'b0}};
  localparam logic [INDEX_BIT-1:0] IDX_LAST     = INDEX_BIT'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [SUM_BIT-1:0] cost_ext(input logic [COST_BIT-1:0] c);
    return SUM_BIT'(c);
  endfunction

endpackage

// File: rtl/cost_tracker_min_count.sv
// Stage 3: keeps the smallest permutation sum seen so far and how many
// permutations hit it; raises done once the final permutation has been compared.
module min_count_tracker
  import cost_tracker_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [SUM_BIT-1:0] sum_i,
  input  logic               sum_v_i,
  input  logic               last_i,
  output logic [SUM_BIT-1:0] min_cost_o,
  output logic [CNT_BIT-1:0] match_count_o,
  output logic               done_o
);

  logic [SUM_BIT-1:0] min_q, min_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;

  always_comb begin
    min_d  = min_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (sum_v_i && !done_q) begin
      if (sum_i < min_q) begin
        min_d = sum_i;
        cnt_d = {{(CNT_BIT-1){1'b0}}, 1'b1};
      end else if (sum_i == min_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        min_d = min_q;
      end
      if (last_i) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      min_q  <= MINCOST_INIT;
      cnt_q  <= {CNT_BIT{1'b0}};
      done_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign min_cost_o    = min_q;
  assign match_count_o = cnt_q;
  assign done_o        = done_q;

endmodule

// File: rtl/cost_tracker.sv
// Permutation-stream sink: addresses the cost ROM per (work, job) pair, sums each
// permutation and reports the minimum sum and its multiplicity after the last one.
module cost_tracker
  import cost_tracker_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [INDEX_BIT-1:0] in_work,
  input  logic [INDEX_BIT-1:0] in_job,
  input  logic                 in_last,
  output logic [INDEX_BIT-1:0] W,
  output logic [INDEX_BIT-1:0] J,
  input  logic [COST_BIT-1:0]  Cost,
  output logic [SUM_BIT-1:0]   MinCost,
  output logic [CNT_BIT-1:0]   MatchCount,
  output logic                 Valid
);

  state_e             state_q, state_d;
  logic [INDEX_BIT-1:0] w_q, w_d, j_q, j_d;
  logic v1_q, v1_d, open1_q, open1_d, close1_q, close1_d, last1_q, last1_d;
  logic v2_q, v2_d, open2_q, open2_d, close2_q, close2_d, last2_q, last2_d;
  logic [SUM_BIT-1:0] acc_q, acc_d;
  logic               sum_v_q, sum_v_d, last3_q, last3_d;
  logic               valid_q;
  logic               done_s, frozen_s, accept_s;

  assign frozen_s = done_s || (state_q == ST_DONE);
  assign accept_s = in_valid && !frozen_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (done_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/tag stage, tag shift, and accumulate stage. Once frozen nothing new enters.
  always_comb begin
    w_d      = w_q;
    j_d      = j_q;
    v1_d     = accept_s;
    open1_d  = accept_s && (in_work == IDX_FIRST);
    close1_d = accept_s && (in_work == IDX_LAST);
    last1_d  = accept_s && (in_work == IDX_LAST) && in_last;
    if (accept_s) begin
      w_d = in_work;
      j_d = in_job;
    end else begin
      w_d = w_q;
      j_d = j_q;
    end

    v2_d     = v1_q && !frozen_s;
    open2_d  = open1_q;
    close2_d = close1_q;
    last2_d  = last1_q;

    acc_d   = acc_q;
    sum_v_d = 1'b0;
    last3_d = 1'b0;
    if (v2_q && !frozen_s) begin
      // An opening pair restarts the sum, dropping any unfinished permutation.
      if (open2_q) acc_d = cost_ext(Cost);
      else         acc_d = acc_q + cost_ext(Cost);
      sum_v_d = close2_q;
      last3_d = close2_q && last2_q;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      w_q      <= {INDEX_BIT{1'b0}};
      j_q      <= {INDEX_BIT{1'b0}};
      v1_q     <= 1'b0;
      open1_q  <= 1'b0;
      close1_q <= 1'b0;
      last1_q  <= 1'b0;
      v2_q     <= 1'b0;
      open2_q  <= 1'b0;
      close2_q <= 1'b0;
      last2_q  <= 1'b0;
      acc_q    <= {SUM_BIT{1'b0}};
      sum_v_q  <= 1'b0;
      last3_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      j_q      <= j_d;
      v1_q     <= v1_d;
      open1_q  <= open1_d;
      close1_q <= close1_d;
      last1_q  <= last1_d;
      v2_q     <= v2_d;
      open2_q  <= open2_d;
      close2_q <= close2_d;
      last2_q  <= last2_d;
      acc_q    <= acc_d;
      sum_v_q  <= sum_v_d;
      last3_q  <= last3_d;
      valid_q  <= done_s;
    end
  end

  // Stage 3 compares the registered sum, so a following open may overwrite acc freely.
  min_count_tracker u_min_count (
    .CLK           (CLK),
    .RST           (RST),
    .sum_i         (acc_q),
    .sum_v_i       (sum_v_q),
    .last_i        (last3_q),
    .min_cost_o    (MinCost),
    .match_count_o (MatchCount),
    .done_o        (done_s)
  );

  assign W     = w_q;
  assign J     = j_q;
  assign Valid = valid_q;

endmodule
